// File: rtl/btn_resource_arbiter.sv
// Four-requester arbiter with grant hold limit, per-requester timeout lockout and a dead cycle
// between owners. Define ARB_ROUND_ROBIN_EN for round-robin selection; default is fixed 3>2>1>0.
module btn_resource_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] grant_idx,
    output logic       grant_valid,
    output logic       idle,
    output logic       timeout
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StGrant = 2'd1;
    localparam logic [1:0] StGap   = 2'd2;

    localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

    logic [1:0] state_q, state_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [3:0] expired_q, expired_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] grant_idx_q, grant_idx_d;
    logic       grant_valid_q, grant_valid_d;
    logic       idle_q, idle_d;
    logic       timeout_q, timeout_d;

    logic [3:0] eligible;
    logic [1:0] win_idx;
    logic       owner_req;

    assign eligible  = req & ~expired_q;
    assign owner_req = req[grant_idx_q];

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic [1:0] cand;

    // Walk offsets from farthest to nearest so the nearest eligible requester wins.
    always_comb begin
        win_idx = 2'd0;
        cand    = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            cand = rr_ptr_q + 2'(k);
            if (eligible[cand]) begin
                win_idx = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= 2'd3;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    always_comb begin
        if (eligible[3]) begin
            win_idx = 2'd3;
        end else if (eligible[2]) begin
            win_idx = 2'd2;
        end else if (eligible[1]) begin
            win_idx = 2'd1;
        end else begin
            win_idx = 2'd0;
        end
    end
`endif

    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        // A lockout bit survives only while its requester keeps asking.
        expired_d     = expired_q & req;
        grant_d       = 4'b0000;
        grant_idx_d   = 2'd0;
        grant_valid_d = 1'b0;
        timeout_d     = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        rr_ptr_d      = rr_ptr_q;
`endif
        case (state_q)
            StGrant: begin
                if (!en || !owner_req) begin
                    state_d = StGap;
                end else if (hold_cnt_q == HoldLast) begin
                    state_d                = StGap;
                    expired_d[grant_idx_q] = 1'b1;
                    timeout_d              = 1'b1;
                end else begin
                    hold_cnt_d    = hold_cnt_q + 8'd1;
                    grant_d       = grant_q;
                    grant_idx_d   = grant_idx_q;
                    grant_valid_d = 1'b1;
                end
            end
            default: begin
                // IDLE and the end of GAP arbitrate identically.
                if (en && (eligible != 4'b0000)) begin
                    state_d       = StGrant;
                    hold_cnt_d    = 8'd0;
                    grant_d       = 4'b0001 << win_idx;
                    grant_idx_d   = win_idx;
                    grant_valid_d = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                    rr_ptr_d      = win_idx;
`endif
                end else begin
                    state_d = StIdle;
                end
            end
        endcase
        idle_d = (state_d == StIdle) && en && (req == 4'b0000);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            hold_cnt_q    <= 8'd0;
            expired_q     <= 4'b0000;
            grant_q       <= 4'b0000;
            grant_idx_q   <= 2'd0;
            grant_valid_q <= 1'b0;
            idle_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            expired_q     <= expired_d;
            grant_q       <= grant_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            idle_q        <= idle_d;
            timeout_q     <= timeout_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign grant_valid = grant_valid_q;
    assign idle        = idle_q;
    assign timeout     = timeout_q;

endmodule

// File: doc/btn_resource_arbiter.md
Name: btn_resource_arbiter

Overview:
- Clocked 4-requester arbiter that shares a single downstream resource (LED/display channel) between button requesters.
- Acts as the sequential successor to the combinational priority encoder: encoder-style index and valid outputs, plus grant hold, timeout and a dead cycle between owners.
- Sits between synchronized button inputs and the shared output datapath.
- Requests arrive already synchronized and debounced upstream.

Parameters:
MAX_HOLD, 16, maximum consecutive cycles one requester may hold the grant; legal range 2..255; counter width 8 bits.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  arbiter enable (Ein equivalent); low forces release and blocks new grants
req  input  4  request vector; bit i = requester i
grant  output  4  one-hot grant; registered
grant_idx  output  2  binary index of current owner; 0 when no grant; registered
grant_valid  output  1  1 while any grant is held (GS equivalent); registered
idle  output  1  1 when en=1, req=0 and no grant is held (Eout equivalent); registered
timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD expiry; registered

Behaviour:
- Reset (async, any time, including mid-grant):
  - state=IDLE; grant=0; grant_idx=0; grant_valid=0; idle=0; timeout=0.
  - hold_cnt=0; expired mask=0; rr pointer=3.
- States: IDLE, GRANT, GAP.
- Eligible set = req & ~expired. A winner is chosen from the eligible set only.
- IDLE:
  - If en=1 and eligible!=0: pick winner, go to GRANT.
  - grant/grant_idx/grant_valid update on the same edge, so req-to-grant latency is 1 cycle.
  - Set hold_cnt=0.
- GRANT, evaluated each cycle in priority order:
  - (a) en=0 -> GAP.
  - (b) req[owner]=0 -> GAP.
  - (c) hold_cnt==MAX_HOLD-1 -> GAP, set expired[owner], timeout=1 for exactly one cycle.
  - (d) otherwise stay in GRANT and increment hold_cnt.
  - Effect: a continuously requesting owner holds the grant for exactly MAX_HOLD cycles.
- GAP:
  - Always exactly one cycle with grant=0, grant_idx=0, grant_valid=0.
  - At the end of GAP, arbitrate as in IDLE: if en=1 and eligible!=0 -> GRANT with new winner; else -> IDLE.
  - Back-to-back owners are therefore separated by exactly one dead cycle.
- Expired mask: expired[i] clears on the cycle after req[i] is sampled 0. A timed-out requester must release before it can win again.
- All requesters expired and still requesting: no grant; idle=0 (req!=0). Stays in IDLE until a request drops.
- en=0:
  - No new grants.
  - A held grant drops one cycle after en falls (via GAP).
  - idle=0.
  - The expired mask continues to clear normally.
- idle is registered: 1 on the cycle after state=IDLE, en=1 and req=0 are sampled. Never 1 while grant_valid=1.
- grant_valid and idle are never both 1. grant is always one-hot or zero. grant_idx always equals the encoded grant.
- Simultaneous release and new request from the same requester in GRANT: release wins, GAP is inserted, and re-arbitration happens at the end of GAP.

Optional Feature:
ARB_ROUND_ROBIN_EN:
- Defined:
  - Round-robin selection. Search starts at (rr_ptr+1) mod 4 and wraps.
  - rr_ptr is loaded with the winner index on each grant.
  - rr_ptr=3 at reset, so the first search order is 0,1,2,3.
- Undefined:
  - Fixed priority 3>2>1>0, identical ordering to the existing encoder.
  - rr_ptr is not implemented.
  - Starvation is bounded only by MAX_HOLD plus the expired mask.

Test Plan:
- Reset release with en=1, req=0 -> idle=1 from 2nd edge; grant=0, grant_idx=0, grant_valid=0.
- en=1, req=4'b0100 at edge k -> at edge k+1 grant=4'b0100, grant_idx=2, grant_valid=1; req drops at edge k+5 -> grant=0 at k+6 (GAP); idle=1 at k+7.
- MAX_HOLD=16, req=4'b1000 held -> grant held 16 cycles, then timeout pulses 1 cycle and grant=0. No regrant while req[3] stays 1; regrant after req[3] toggles 0 then 1.
- Fixed priority, req=4'b1011 all held -> grant idx 3, then idx 1 after timeout + GAP, then idx 0. ROUND_ROBIN build, same stimulus from reset -> order 0, 1, 3.
- Grant held on idx 1, en dropped -> grant=0 next edge, grant_valid=0, idle=0. en restored with req=4'b0010 still high -> regrant idx 1 after 1 cycle.
- rst asserted mid-GRANT asynchronously -> all outputs 0 immediately, without waiting for a clock edge. After release, arbitration restarts from IDLE with the expired mask cleared.
